// File: rtl/surf_bitslip_align_if.sv
// Byte-lane link between the ISERDES-side aligner and whoever drives/observes it.
// The aligner is the slave: it receives data/requests and returns slip/lock status.
interface surf_bitslip_align_if;
  logic [7:0] data_i;
  logic       align_req_i;
  logic       bitslip_o;
  logic       locked_o;
  logic       fail_o;
  logic       capture_o;
  logic [3:0] slip_count_o;

  modport slave (
    input  data_i, align_req_i,
    output bitslip_o, locked_o, fail_o, capture_o, slip_count_o
  );

  modport master (
    output data_i, align_req_i,
    input  bitslip_o, locked_o, fail_o, capture_o, slip_count_o
  );
endinterface

// File: rtl/surf_bitslip_align.sv
// Training-pattern aligner for one SURF byte lane: slips the ISERDES until
// TRAIN_PATTERN repeats MATCH_COUNT times, then locks and pulses capture.
module surf_bitslip_align #(
  parameter logic [7:0]  TRAIN_PATTERN = 8'hA6,
  parameter int unsigned MATCH_COUNT   = 4,
  parameter int unsigned MAX_SLIPS     = 8,
  parameter int unsigned BITSLIP_WAIT  = 3
) (
  input logic                 sysclk_i,
  input logic                 rst_n_i,
  surf_bitslip_align_if.slave lane
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_SLIP,
    S_WAIT,
    S_LOCKED,
    S_FAIL
  } state_t;

  localparam logic [3:0] MATCH_LAST = 4'(MATCH_COUNT - 1);
  localparam logic [3:0] SLIP_MAX   = 4'(MAX_SLIPS);
  localparam logic [3:0] WAIT_LAST  = 4'(BITSLIP_WAIT - 1);

  state_t     r_state;
  logic [3:0] r_match_cnt;
  logic [3:0] r_slip_cnt;
  logic [3:0] r_wait_cnt;
  logic       r_bitslip;
  logic       r_locked;
  logic       r_fail;
  logic       r_capture;

  assign lane.bitslip_o    = r_bitslip;
  assign lane.locked_o     = r_locked;
  assign lane.fail_o       = r_fail;
  assign lane.capture_o    = r_capture;
  assign lane.slip_count_o = r_slip_cnt;

  always_ff @(posedge sysclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state     <= S_IDLE;
      r_match_cnt <= '0;
      r_slip_cnt  <= '0;
      r_wait_cnt  <= '0;
      r_bitslip   <= 1'b0;
      r_locked    <= 1'b0;
      r_fail      <= 1'b0;
      r_capture   <= 1'b0;
    end else begin
      // Pulses default low; a pulse registered on the previous edge still
      // completes its one cycle even when a restart request arrives.
      r_bitslip <= 1'b0;
      r_capture <= 1'b0;
      if (lane.align_req_i) begin
        r_state     <= S_CHECK;
        r_match_cnt <= '0;
        r_slip_cnt  <= '0;
        r_wait_cnt  <= '0;
        r_locked    <= 1'b0;
        r_fail      <= 1'b0;
      end else begin
        unique case (r_state)
          S_IDLE: ;
          S_CHECK: begin
            if (lane.data_i == TRAIN_PATTERN) begin
              r_match_cnt <= r_match_cnt + 4'd1;
              if (r_match_cnt == MATCH_LAST) begin
                r_state   <= S_LOCKED;
                r_locked  <= 1'b1;
                r_capture <= 1'b1;
              end
            end else begin
              r_match_cnt <= '0;
              if (r_slip_cnt == SLIP_MAX) begin
                r_state <= S_FAIL;
                r_fail  <= 1'b1;
              end else begin
                // Slip count advances with the pulse so the port tracks it.
                r_state    <= S_SLIP;
                r_bitslip  <= 1'b1;
                r_slip_cnt <= r_slip_cnt + 4'd1;
              end
            end
          end
          S_SLIP: begin
            r_state    <= S_WAIT;
            r_wait_cnt <= '0;
          end
          S_WAIT: begin
            if (r_wait_cnt == WAIT_LAST) begin
              r_wait_cnt <= '0;
              r_state    <= S_CHECK;
            end else begin
              r_wait_cnt <= r_wait_cnt + 4'd1;
            end
          end
          S_LOCKED: ;
          S_FAIL: ;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
